uart_sha_host: RTL and testbench
================================

// Module: uart_sha_host
// PURPOSE
//  Host-side initiator for the UART SHA-256d mining protocol: takes one job, resets and greets the
//  remote hasher, streams the 136-byte job, then collects the found nonce. Sits between job logic and
//  a uart_tx/uart_rx pair (byte valid/ready) on a test FPGA or loopback bench opposite the hasher.
// PARAMETERS
//  ACK_TIMEOUT    100_000  clk cycles allowed for each 'O'/'1'/'S' reply and each nonce byte; 0 = off
//  RESULT_TIMEOUT 0        clk cycles allowed from 'S' to 'Y'; 0 = wait forever
// PORTS
//  clk            in   1    clock
//  in_rst         in   1    reset, synchronous, active-high
//  job_valid      in   1    job offered
//  job_ready      out  1    high only in IDLE; job taken on job_valid&&job_ready
//  job_data       in   512  block bytes; byte i = job_data[8i+:8]
//  job_state      in   256  midstate; byte k = [8k+:8]
//  job_target     in   256  target; byte k = [8k+:8]
//  job_nonce_base in   32   first nonce; byte k = [8k+:8]
//  job_position   in   32   nonce byte position; byte k = [8k+:8]
//  tx_data        out  8    byte to uart_tx
//  tx_valid       out  1    held with tx_data until tx_ready
//  tx_ready       in   1    uart_tx accepts byte this cycle
//  rx_data        in   8    byte from uart_rx
//  rx_valid       in   1    one-cycle strobe per received byte
//  res_valid      out  1    one-cycle pulse: res_nonce valid
//  res_nonce      out  32   found nonce, held until next job accepted
//  err_valid      out  1    one-cycle pulse: job aborted
//  err_code       out  2    1 unexpected byte, 2 timeout, 3 remote error ('E'/'e')
//  err_byte       out  8    offending rx byte (0 for timeout)
//  busy           out  1    ~IDLE
// BEHAVIOUR
//  - Reset: IDLE; tx_valid, res_valid, err_valid, busy 0; job_ready 1; res_nonce, err_* 0.
//  - Accept cycle registers all job fields; fields are not sampled afterwards.
//  - Sequence: TX_RST 'R' -> WAIT_O -> TX_HELLO 'H' -> WAIT_1 -> TX_JOB -> WAIT_S -> WAIT_Y
//    -> RX_NONCE -> IDLE. Every job starts with 'R' because remote state is unknown.
//  - TX rule: tx_valid/tx_data set on state entry and stable until tx_valid&&tx_ready. Next byte
//    follows in the cycle after; no combinational path from tx_ready to tx_data.
//  - TX_JOB: byte counter 0..135. Order: data 0..63, state 0..31, target 0..31, nonce_base 0..3,
//    position 0..3. Leave on handshake of byte 135.
//  - WAIT states change only on rx_valid. Expected byte advances. 'E'/'e' gives code 3.
//    Any other byte gives code 1. Any rx_valid during TX_* states also gives code 1.
//  - RX_NONCE: four bytes, LSB first, into res_nonce[8k+:8]. After the 4th, pulse res_valid and
//    return to IDLE. No rx byte can be an error here.
//  - Timeout: down-counter loaded on entry to each WAIT/RX state and on each accepted nonce byte.
//    Zero means code 2. WAIT_Y uses RESULT_TIMEOUT; the others use ACK_TIMEOUT.
//  - Error: err_valid pulses one cycle and the block enters IDLE the same cycle; tx_valid drops.
//  - rx_valid and tx_ready in the same cycle: both are evaluated; rx error takes priority.
//  - in_rst mid-job aborts silently: no res/err pulse. A byte already in uart_tx is not recalled.
// STRUCTURE
//  - uart_sha_pkg: CMD_RESET/CMD_HELLO/ACK_RESET/ACK_HELLO/ACK_START/ACK_RESULT/NAK_*.
//    Also JOB_BYTES=136, the state enum, the err_code enum, and function job_byte(idx, fields).
//  - No sub-module; a single FSM with byte, nonce and timeout counters.
// TESTING
//  - Nominal job (data[i]=i, nonce_base=0x01020304) with model replies O,1,S,Y,EF,BE,AD,DE ->
//    tx stream R,H, then 136 bytes in the order above; res_nonce=0xDEADBEEF; one res_valid.
//  - tx_ready held low 50 cycles mid-job -> tx_data stable, no byte lost or duplicated.
//  - Model replies 'E' to 'H' -> err_valid, err_code=3, err_byte=0x45; job_ready next cycle.
//  - Silence after 'R' with ACK_TIMEOUT=16 -> err_code=2 exactly 16 cycles after entering WAIT_O.
//  - Stray 0x55 during TX_JOB -> err_code=1, err_byte=0x55, tx_valid low.
//  - in_rst at job byte 70 -> IDLE, no pulses; next job completes normally starting with 'R'.

Source files
------------

// File: rtl/uart_sha_pkg.sv
// ---------------------------------------------------------------------------
// uart_sha_pkg
// Shared definitions for the host side of the UART SHA-256d mining protocol:
// command/reply byte values, job length, FSM state and error-code enums, the
// packed job record and a helper that returns job byte N in wire order.
// ---------------------------------------------------------------------------
package uart_sha_pkg;

    localparam logic [7:0] CMD_RESET  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_HELLO  = 8'h48;  // 'H'
    localparam logic [7:0] ACK_RESET  = 8'h4F;  // 'O'
    localparam logic [7:0] ACK_HELLO  = 8'h31;  // '1'
    localparam logic [7:0] ACK_START  = 8'h53;  // 'S'
    localparam logic [7:0] ACK_RESULT = 8'h59;  // 'Y'
    localparam logic [7:0] NAK_UPPER  = 8'h45;  // 'E'
    localparam logic [7:0] NAK_LOWER  = 8'h65;  // 'e'

    localparam int JOB_BYTES = 136;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_RST,
        S_WAIT_O,
        S_TX_HELLO,
        S_WAIT_1,
        S_TX_JOB,
        S_WAIT_S,
        S_WAIT_Y,
        S_RX_NONCE
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_UNEXPECTED = 2'd1,
        ERR_TIMEOUT    = 2'd2,
        ERR_REMOTE     = 2'd3
    } err_code_e;

    // Field order is chosen so that the flattened record is exactly the wire
    // order: data occupies the least significant bytes, position the top.
    typedef struct packed {
        logic [31:0]  position;
        logic [31:0]  nonce_base;
        logic [255:0] target;
        logic [255:0] state;
        logic [511:0] data;
    } job_t;

    function automatic logic [7:0] job_byte(input logic [7:0] idx, input job_t fields);
        logic [JOB_BYTES*8-1:0] flat;
        flat = fields;
        return flat[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_sha_host_if.sv
// ---------------------------------------------------------------------------
// uart_sha_host_if
// Bundles the job hand-off, byte-stream UART side and result/error reporting
// of uart_sha_host.
//   slave  : view used by uart_sha_host (accepts jobs, drives tx, reports)
//   master : view used by job logic / UART models around it
// ---------------------------------------------------------------------------
interface uart_sha_host_if;
    import uart_sha_pkg::*;

    logic         job_valid;
    logic         job_ready;
    logic [511:0] job_data;
    logic [255:0] job_state;
    logic [255:0] job_target;
    logic [31:0]  job_nonce_base;
    logic [31:0]  job_position;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         res_valid;
    logic [31:0]  res_nonce;
    logic         err_valid;
    err_code_e    err_code;
    logic [7:0]   err_byte;
    logic         busy;

    modport slave (
        input  job_valid, job_data, job_state, job_target, job_nonce_base, job_position,
        input  tx_ready, rx_data, rx_valid,
        output job_ready, tx_data, tx_valid,
        output res_valid, res_nonce, err_valid, err_code, err_byte, busy
    );

    modport master (
        output job_valid, job_data, job_state, job_target, job_nonce_base, job_position,
        output tx_ready, rx_data, rx_valid,
        input  job_ready, tx_data, tx_valid,
        input  res_valid, res_nonce, err_valid, err_code, err_byte, busy
    );
endinterface

// File: rtl/uart_sha_host.sv
// ---------------------------------------------------------------------------
// uart_sha_host
// Host-side initiator: takes one job, sends 'R' (wait 'O'), 'H' (wait '1'),
// streams the 136-byte job (wait 'S', then 'Y'), collects a 4-byte nonce.
// Ports:
//   clk     clock
//   in_rst  synchronous active-high reset (aborts a job silently)
//   bus     uart_sha_host_if.slave: job in, tx/rx byte streams, result/error
// Parameters:
//   ACK_TIMEOUT     cycles allowed per reply / nonce byte (0 = never)
//   RESULT_TIMEOUT  cycles allowed from 'S' to 'Y' (0 = never)
// ---------------------------------------------------------------------------
module uart_sha_host
    import uart_sha_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT    = 100_000,
    parameter int unsigned RESULT_TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           in_rst,
    uart_sha_host_if.slave bus
);

    localparam logic [31:0] ACK_LOAD    = 32'(ACK_TIMEOUT);
    localparam logic [31:0] RESULT_LOAD = 32'(RESULT_TIMEOUT);
    localparam logic [7:0]  LAST_BYTE   = 8'(JOB_BYTES - 1);

    state_e      r_state, w_state_next;
    job_t        r_job, w_job_next;
    logic [7:0]  r_tx_data, w_tx_data_next;
    logic        r_tx_valid, w_tx_valid_next;
    logic [7:0]  r_byte_cnt, w_byte_cnt_next;
    logic [1:0]  r_nonce_cnt, w_nonce_cnt_next;
    logic [31:0] r_tmo, w_tmo_next;
    logic        r_res_valid, w_res_valid_next;
    logic [31:0] r_res_nonce, w_res_nonce_next;
    logic        r_err_valid, w_err_valid_next;
    err_code_e   r_err_code, w_err_code_next;
    logic [7:0]  r_err_byte, w_err_byte_next;

    logic        w_in_wait, w_tmo_on, w_tmo_hit;
    logic        w_abort;
    err_code_e   w_abort_code;
    logic [7:0]  w_abort_byte;
    logic [7:0]  w_expect;

    always_comb begin
        w_state_next     = r_state;
        w_job_next       = r_job;
        w_tx_data_next   = r_tx_data;
        w_tx_valid_next  = r_tx_valid;
        w_byte_cnt_next  = r_byte_cnt;
        w_nonce_cnt_next = r_nonce_cnt;
        w_res_valid_next = 1'b0;
        w_res_nonce_next = r_res_nonce;
        w_err_valid_next = 1'b0;
        w_err_code_next  = r_err_code;
        w_err_byte_next  = r_err_byte;
        w_abort          = 1'b0;
        w_abort_code     = ERR_UNEXPECTED;
        w_abort_byte     = bus.rx_data;

        unique case (r_state)
            S_WAIT_O: w_expect = ACK_RESET;
            S_WAIT_1: w_expect = ACK_HELLO;
            S_WAIT_S: w_expect = ACK_START;
            default:  w_expect = ACK_RESULT;
        endcase

        // The counter holds the cycles left; it expires in the cycle it
        // would step from 1 to 0. A byte arriving that cycle still wins.
        w_in_wait  = (r_state == S_WAIT_O) || (r_state == S_WAIT_1) || (r_state == S_WAIT_S) ||
                     (r_state == S_WAIT_Y) || (r_state == S_RX_NONCE);
        w_tmo_on   = (r_state == S_WAIT_Y) ? (RESULT_TIMEOUT != 0) : (ACK_TIMEOUT != 0);
        w_tmo_hit  = w_in_wait && w_tmo_on && (r_tmo == 32'd1);
        w_tmo_next = (w_in_wait && w_tmo_on && (r_tmo != 32'd0)) ? r_tmo - 32'd1 : r_tmo;

        case (r_state)
            S_IDLE: begin
                if (bus.job_valid) begin
                    w_job_next       = {bus.job_position, bus.job_nonce_base, bus.job_target,
                                        bus.job_state, bus.job_data};
                    w_state_next     = S_TX_RST;
                    w_tx_valid_next  = 1'b1;
                    w_tx_data_next   = CMD_RESET;
                    w_res_nonce_next = '0;
                end
            end
            S_TX_RST, S_TX_HELLO, S_TX_JOB: begin
                // Any received byte while we are still talking is a protocol
                // violation, even if the tx handshake completes this cycle.
                if (bus.rx_valid) begin
                    w_abort = 1'b1;
                end else if (r_tx_valid && bus.tx_ready) begin
                    if ((r_state == S_TX_JOB) && (r_byte_cnt != LAST_BYTE)) begin
                        w_byte_cnt_next = r_byte_cnt + 8'd1;
                        w_tx_data_next  = job_byte(r_byte_cnt + 8'd1, r_job);
                    end else begin
                        w_tx_valid_next = 1'b0;
                        w_tmo_next      = ACK_LOAD;
                        if (r_state == S_TX_RST)        w_state_next = S_WAIT_O;
                        else if (r_state == S_TX_HELLO) w_state_next = S_WAIT_1;
                        else                            w_state_next = S_WAIT_S;
                    end
                end
            end
            S_WAIT_O, S_WAIT_1, S_WAIT_S, S_WAIT_Y: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == w_expect) begin
                        case (r_state)
                            S_WAIT_O: begin
                                w_state_next    = S_TX_HELLO;
                                w_tx_valid_next = 1'b1;
                                w_tx_data_next  = CMD_HELLO;
                            end
                            S_WAIT_1: begin
                                w_state_next    = S_TX_JOB;
                                w_byte_cnt_next = 8'd0;
                                w_tx_valid_next = 1'b1;
                                w_tx_data_next  = job_byte(8'd0, r_job);
                            end
                            S_WAIT_S: begin
                                w_state_next = S_WAIT_Y;
                                w_tmo_next   = RESULT_LOAD;
                            end
                            default: begin
                                w_state_next     = S_RX_NONCE;
                                w_nonce_cnt_next = 2'd0;
                                w_tmo_next       = ACK_LOAD;
                            end
                        endcase
                    end else begin
                        w_abort      = 1'b1;
                        w_abort_code = ((bus.rx_data == NAK_UPPER) || (bus.rx_data == NAK_LOWER))
                                       ? ERR_REMOTE : ERR_UNEXPECTED;
                    end
                end else if (w_tmo_hit) begin
                    w_abort      = 1'b1;
                    w_abort_code = ERR_TIMEOUT;
                    w_abort_byte = 8'h00;
                end
            end
            S_RX_NONCE: begin
                if (bus.rx_valid) begin
                    w_res_nonce_next[{r_nonce_cnt, 3'b000} +: 8] = bus.rx_data;
                    w_tmo_next = ACK_LOAD;
                    if (r_nonce_cnt == 2'd3) begin
                        w_res_valid_next = 1'b1;
                        w_state_next     = S_IDLE;
                    end else begin
                        w_nonce_cnt_next = r_nonce_cnt + 2'd1;
                    end
                end else if (w_tmo_hit) begin
                    w_abort      = 1'b1;
                    w_abort_code = ERR_TIMEOUT;
                    w_abort_byte = 8'h00;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_abort) begin
            w_state_next     = S_IDLE;
            w_tx_valid_next  = 1'b0;
            w_err_valid_next = 1'b1;
            w_err_code_next  = w_abort_code;
            w_err_byte_next  = w_abort_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            r_state     <= S_IDLE;
            r_job       <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_byte_cnt  <= '0;
            r_nonce_cnt <= '0;
            r_tmo       <= '0;
            r_res_valid <= 1'b0;
            r_res_nonce <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_byte  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_job       <= w_job_next;
            r_tx_data   <= w_tx_data_next;
            r_tx_valid  <= w_tx_valid_next;
            r_byte_cnt  <= w_byte_cnt_next;
            r_nonce_cnt <= w_nonce_cnt_next;
            r_tmo       <= w_tmo_next;
            r_res_valid <= w_res_valid_next;
            r_res_nonce <= w_res_nonce_next;
            r_err_valid <= w_err_valid_next;
            r_err_code  <= w_err_code_next;
            r_err_byte  <= w_err_byte_next;
        end
    end

    assign bus.job_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.res_valid = r_res_valid;
    assign bus.res_nonce = r_res_nonce;
    assign bus.err_valid = r_err_valid;
    assign bus.err_code  = r_err_code;
    assign bus.err_byte  = r_err_byte;

endmodule

// File: tb/tb_uart_sha_host.sv
// ---------------------------------------------------------------------------
// tb_uart_sha_host
// Drives jobs into uart_sha_host, plays the remote hasher on the rx side and
// compares the transmitted byte stream, results and errors with expectations
// built directly from the job fields and the protocol rules.
// ---------------------------------------------------------------------------
module tb_uart_sha_host;
    import uart_sha_pkg::*;

    localparam int ACK_T = 16;

    logic clk    = 1'b0;
    logic in_rst = 1'b1;
    always #5 clk = ~clk;

    uart_sha_host_if bus ();

    uart_sha_host #(.ACK_TIMEOUT(ACK_T), .RESULT_TIMEOUT(0)) dut (
        .clk    (clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          res_cnt = 0;
    int          err_cnt = 0;
    int          res0;
    int          err0;
    logic [31:0] last_nonce = '0;
    logic [7:0]  got_tx[$];
    logic [7:0]  exp_tx[$];
    bit          stall = 1'b0;
    int          ready_mode = 0;

    logic [511:0] j_data;
    logic [255:0] j_state;
    logic [255:0] j_target;
    logic [31:0]  j_nb;
    logic [31:0]  j_pos;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed tx handshake and every result/error pulse.
    always @(negedge clk) begin
        if (!in_rst) begin
            if (bus.tx_valid && bus.tx_ready) got_tx.push_back(bus.tx_data);
            if (bus.res_valid) begin
                res_cnt    <= res_cnt + 1;
                last_nonce <= bus.res_nonce;
            end
            if (bus.err_valid) err_cnt <= err_cnt + 1;
        end
    end

    // uart_tx model: ready decided just after each rising edge
    always @(posedge clk) begin
        #1;
        if (stall)                bus.tx_ready = 1'b0;
        else if (ready_mode == 0) bus.tx_ready = 1'b1;
        else                      bus.tx_ready = ($urandom_range(3) != 0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic reply(input logic [7:0] b);
        idle(1 + int'($urandom_range(0, 3)));
        send_rx(b);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (got_tx.size() < n && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (got_tx.size() < n) check({tag, "_wait_tx_timeout"}, got_tx.size(), n);
    endtask

    task automatic rand_job();
        for (int i = 0; i < 16; i++) j_data[32*i +: 32] = $urandom();
        for (int i = 0; i < 8; i++) begin
            j_state[32*i +: 32]  = $urandom();
            j_target[32*i +: 32] = $urandom();
        end
        j_nb  = $urandom();
        j_pos = $urandom();
    endtask

    // Wire order: 'R', 'H', data 0..63, state 0..31, target 0..31, nonce_base 0..3, position 0..3
    task automatic build_exp();
        exp_tx.delete();
        exp_tx.push_back(8'h52);
        exp_tx.push_back(8'h48);
        for (int i = 0; i < 64; i++) exp_tx.push_back(j_data[8*i +: 8]);
        for (int i = 0; i < 32; i++) exp_tx.push_back(j_state[8*i +: 8]);
        for (int i = 0; i < 32; i++) exp_tx.push_back(j_target[8*i +: 8]);
        for (int i = 0; i < 4; i++)  exp_tx.push_back(j_nb[8*i +: 8]);
        for (int i = 0; i < 4; i++)  exp_tx.push_back(j_pos[8*i +: 8]);
    endtask

    task automatic offer_job();
        int k = 0;
        got_tx.delete();
        build_exp();
        res0 = res_cnt;
        err0 = err_cnt;
        while (!bus.job_ready && k < 100) begin
            idle(1);
            k++;
        end
        if (!bus.job_ready) check("offer_job_ready", bus.job_ready, 1);
        bus.job_data       = j_data;
        bus.job_state      = j_state;
        bus.job_target     = j_target;
        bus.job_nonce_base = j_nb;
        bus.job_position   = j_pos;
        bus.job_valid      = 1'b1;
        idle(1);
        bus.job_valid      = 1'b0;
        // Fields must have been captured at accept; garbage from here on.
        for (int i = 0; i < 16; i++) bus.job_data[32*i +: 32] = $urandom();
        bus.job_state      = ~j_state;
        bus.job_target     = ~j_target;
        bus.job_nonce_base = $urandom();
        bus.job_position   = $urandom();
    endtask

    task automatic compare_stream(input string name);
        check({name, "_tx_count"}, got_tx.size(), exp_tx.size());
        for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
            check($sformatf("%s_tx_byte%0d", name, i), got_tx[i], exp_tx[i]);
    endtask

    task automatic do_stall(input int n, input string name);
        logic [7:0] held;
        int         sz;
        int         viol = 0;
        wait_tx(2 + n, name);
        stall = 1'b1;
        @(negedge clk);
        #2;
        held = bus.tx_data;
        sz   = got_tx.size();
        repeat (50) begin
            if (!(bus.tx_valid === 1'b1 && bus.tx_data === held)) viol++;
            @(negedge clk);
            #2;
        end
        check({name, "_stall_hold_violations"}, viol, 0);
        check({name, "_stall_no_handshake"}, got_tx.size(), sz);
        stall = 1'b0;
    endtask

    task automatic run_ok(input int stall_at, input logic [31:0] nonce, input bit slow_y,
                          input string name);
        offer_job();
        wait_tx(1, name);
        reply(8'h4F);
        wait_tx(2, name);
        reply(8'h31);
        if (stall_at >= 0) do_stall(stall_at, name);
        wait_tx(138, name);
        reply(8'h53);
        if (slow_y) idle(3 * ACK_T);
        reply(8'h59);
        for (int k = 0; k < 4; k++) reply(nonce[8*k +: 8]);
        idle(2);
        compare_stream(name);
        check({name, "_res_pulses"}, res_cnt - res0, 1);
        check({name, "_err_pulses"}, err_cnt - err0, 0);
        check({name, "_res_nonce"}, bus.res_nonce, nonce);
        check({name, "_pulse_nonce"}, last_nonce, nonce);
        check({name, "_job_ready"}, bus.job_ready, 1);
    endtask

    // stage: 0 WAIT_O, 1 WAIT_1, 2 WAIT_S, 3 WAIT_Y, 4 TX_JOB, 5 TX_RST
    task automatic run_err(input int stage, input logic [7:0] b, input int code, input string name);
        offer_job();
        if (stage == 5) begin
            send_rx(b);
        end else begin
            wait_tx(1, name);
            if (stage == 0) reply(b);
            else begin
                reply(8'h4F);
                wait_tx(2, name);
                if (stage == 1) reply(b);
                else begin
                    reply(8'h31);
                    if (stage == 4) begin
                        wait_tx(12, name);
                        send_rx(b);
                    end else begin
                        wait_tx(138, name);
                        if (stage == 2) reply(b);
                        else begin
                            reply(8'h53);
                            reply(b);
                        end
                    end
                end
            end
        end
        check({name, "_err_valid"}, bus.err_valid, 1);
        check({name, "_err_code"}, bus.err_code, code);
        check({name, "_err_byte"}, bus.err_byte, b);
        check({name, "_tx_valid"}, bus.tx_valid, 0);
        check({name, "_job_ready"}, bus.job_ready, 1);
        idle(1);
        check({name, "_err_one_cycle"}, bus.err_valid, 0);
        check({name, "_err_pulses"}, err_cnt - err0, 1);
        check({name, "_res_pulses"}, res_cnt - res0, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          hs;
        int          stage;
        logic [7:0]  b;
        logic [7:0]  ack;
        int          code;

        bus.job_valid      = 1'b0;
        bus.job_data       = '0;
        bus.job_state      = '0;
        bus.job_target     = '0;
        bus.job_nonce_base = '0;
        bus.job_position   = '0;
        bus.rx_data        = '0;
        bus.rx_valid       = 1'b0;
        bus.tx_ready       = 1'b1;

        idle(3);
        in_rst = 1'b0;
        idle(1);
        check("rst_job_ready", bus.job_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_err_valid", bus.err_valid, 0);
        check("rst_res_nonce", bus.res_nonce, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_err_byte", bus.err_byte, 0);

        // Nominal job
        for (int i = 0; i < 64; i++) j_data[8*i +: 8] = 8'(i);
        j_state = '0; j_target = '0; j_pos = '0;
        for (int i = 0; i < 8; i++) j_target[32*i +: 32] = $urandom();
        j_nb = 32'h01020304;
        run_ok(-1, 32'hDEADBEEF, 1'b0, "nominal");

        // Back-pressure for 50 cycles mid-job
        rand_job();
        run_ok(30, $urandom(), 1'b0, "stall");

        // Remote rejects 'H'
        rand_job();
        run_err(1, 8'h45, 3, "nak_hello");

        // Silence after 'R'
        rand_job();
        offer_job();
        wait_tx(1, "tmo");
        hs  = cyc + 1;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            idle(1);
            if (bus.err_valid) begin
                lat = cyc - hs;
                break;
            end
        end
        check("tmo_latency", lat, ACK_T);
        check("tmo_err_code", bus.err_code, 2);
        check("tmo_err_byte", bus.err_byte, 0);
        check("tmo_job_ready", bus.job_ready, 1);

        // Stray byte while streaming the job
        rand_job();
        run_err(4, 8'h55, 1, "stray_job");

        // Reset in the middle of the job stream
        rand_job();
        offer_job();
        wait_tx(1, "midrst");
        reply(8'h4F);
        wait_tx(2, "midrst");
        reply(8'h31);
        wait_tx(72, "midrst");
        in_rst = 1'b1;
        idle(3);
        in_rst = 1'b0;
        idle(1);
        check("midrst_res_pulses", res_cnt - res0, 0);
        check("midrst_err_pulses", err_cnt - err0, 0);
        check("midrst_job_ready", bus.job_ready, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_tx_valid", bus.tx_valid, 0);
        rand_job();
        run_ok(-1, $urandom(), 1'b0, "post_rst");

        // 'Y' arriving long after ACK_TIMEOUT must be fine with no result timeout
        rand_job();
        run_ok(-1, $urandom(), 1'b1, "slow_y");

        // Random jobs with random back-pressure
        for (int n = 0; n < 5; n++) begin
            ready_mode = int'($urandom_range(0, 1));
            rand_job();
            run_ok(-1, $urandom(), 1'b0, $sformatf("rand%0d", n));
        end

        // Random protocol faults
        for (int n = 0; n < 8; n++) begin
            ready_mode = int'($urandom_range(0, 1));
            stage = int'($urandom_range(0, 5));
            case ($urandom_range(0, 2))
                0:       b = 8'h45;
                1:       b = 8'h65;
                default: b = 8'($urandom());
            endcase
            case (stage)
                0:       ack = 8'h4F;
                1:       ack = 8'h31;
                2:       ack = 8'h53;
                default: ack = 8'h59;
            endcase
            if (stage < 4 && b == ack) b = 8'h00;
            if (stage >= 4)                     code = 1;
            else if (b == 8'h45 || b == 8'h65) code = 3;
            else                                code = 1;
            rand_job();
            run_err(stage, b, code, $sformatf("fault%0d_s%0d", n, stage));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
